// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory write pattern generator:
// FSM states, addressing modes and the LFSR polynomial.
package mem_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_STREAM = 3'd2,
      ST_WAIT   = 3'd3,
      ST_NEXT   = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      MODE_STRIDE = 2'd0,
      MODE_RANDOM = 2'd1,
      MODE_FIXED  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   // x^32 + x^22 + x^2 + x + 1, expressed as state bits 31, 21, 1 and 0
   localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

   function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/mem_test_lfsr.sv
// 32-bit Fibonacci LFSR with seed load and step enable; exposes the value
// the register takes on its next step so callers can use it in the same cycle.
module mem_test_lfsr
   import mem_test_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] step_value
);

   logic [31:0] state_reg;

   assign step_value = lfsr_advance(state_reg);

   // An all-zero seed would lock the LFSR, so it is swapped for the default
   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg <= DEFAULT_SEED;
      end else if (load) begin
         state_reg <= (seed == 32'd0) ? DEFAULT_SEED : seed;
      end else if (step) begin
         state_reg <= step_value;
      end
   end

endmodule

// File: rtl/mem_write_pattern_gen.sv
// Issues a sequence of write commands to a write master and streams a
// counting data pattern for each, walking the address window by mode.
module mem_write_pattern_gen
   import mem_test_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int MEM_ADDR_SIZE      = 32
)
(
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          ap_start,
   output logic                          ap_done,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   input  logic [1:0]                    ctrl_mode,
   input  logic [MEM_ADDR_SIZE-1:0]      addr_increment,
   input  logic [MEM_ADDR_SIZE-1:0]      mem_max_addr,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_bytes,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_num_xfers,
   input  logic [31:0]                   ctrl_constant,
   input  logic [31:0]                   ctrl_seed,
   output logic                          write_out_data,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] write_addr,
   output logic [C_XFER_SIZE_WIDTH-1:0]  out_data_size,
   input  logic                          write_done,
   output logic                          out_data_valid,
   input  logic                          out_data_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
   output logic [C_XFER_SIZE_WIDTH-1:0]  xfer_count
);

   localparam int DW_BYTES   = C_M_AXI_DATA_WIDTH / 8;
   localparam int LANES      = C_M_AXI_DATA_WIDTH / 32;
   localparam int BEAT_SHIFT = $clog2(DW_BYTES);
   localparam int XW         = C_XFER_SIZE_WIDTH;
   localparam int MW         = MEM_ADDR_SIZE;
   localparam int SUM_W      = ((MW > XW) ? MW : XW) + 2;

   state_e              state_reg, state_next;
   mode_e               mode_reg;
   logic [C_M_AXI_ADDR_WIDTH-1:0] base_reg;
   logic [MW-1:0]       inc_reg, max_reg, offset_reg, offset_next;
   logic [XW-1:0]       xfer_bytes_reg, num_xfers_reg, beats_reg, beat_cnt_reg, count_reg;
   logic [31:0]         constant_reg, beat_idx_reg, beat_base;
   logic                done_flag_reg;
   logic                start_accept, beat_fire, last_beat, last_xfer, lfsr_step;
   logic [31:0]         lfsr_step_value;
   logic [XW:0]         beats_round;
   logic [SUM_W-1:0]    stride_sum;
   logic                stride_wrap;
   logic [MW-1:0]       random_offset;

   assign start_accept = (state_reg == ST_IDLE) && ap_start;
   assign beat_fire    = out_data_valid && out_data_ready;
   assign last_beat    = (beat_cnt_reg == beats_reg - XW'(1));
   assign last_xfer    = (count_reg + XW'(1) == num_xfers_reg);
   assign beats_round  = {1'b0, ctrl_xfer_bytes} + (XW+1)'(DW_BYTES - 1);
   assign lfsr_step    = (state_reg == ST_NEXT) && (mode_reg == MODE_RANDOM);

   mem_test_lfsr u_lfsr (
      .clk        (aclk),
      .srst       (areset),
      .load       (start_accept),
      .seed       (ctrl_seed),
      .step       (lfsr_step),
      .step_value (lfsr_step_value)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (ap_start) state_next = (ctrl_num_xfers == '0) ? ST_DONE : ST_ISSUE;
         ST_ISSUE:  state_next = (beats_reg == '0) ? ST_WAIT : ST_STREAM;
         ST_STREAM: if (beat_fire && last_beat) state_next = ST_WAIT;
         ST_WAIT:   if (done_flag_reg) state_next = ST_NEXT;
         ST_NEXT:   state_next = last_xfer ? ST_DONE : ST_ISSUE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      write_out_data = 1'b0;
      out_data_valid = 1'b0;
      ap_done        = 1'b0;
      case (state_reg)
         ST_ISSUE:  write_out_data = 1'b1;
         ST_STREAM: out_data_valid = 1'b1;
         ST_DONE:   ap_done        = 1'b1;
         default:   ;
      endcase
   end

   // Sums are widened past both operand widths so the wrap test cannot overflow
   assign stride_sum    = SUM_W'(offset_reg) + SUM_W'(inc_reg);
   assign stride_wrap   = (stride_sum + SUM_W'(xfer_bytes_reg)) > SUM_W'(max_reg);
   assign random_offset = MW'(lfsr_step_value) & (max_reg - MW'(1)) & ~MW'(DW_BYTES - 1);

   always_comb begin
      offset_next = offset_reg;
      case (mode_reg)
         MODE_RANDOM: offset_next = random_offset;
         MODE_FIXED:  offset_next = offset_reg;
         default:     offset_next = stride_wrap ? '0 : stride_sum[MW-1:0];
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         mode_reg       <= MODE_STRIDE;
         base_reg       <= '0;
         inc_reg        <= '0;
         max_reg        <= '0;
         offset_reg     <= '0;
         xfer_bytes_reg <= '0;
         num_xfers_reg  <= '0;
         beats_reg      <= '0;
         beat_cnt_reg   <= '0;
         count_reg      <= '0;
         constant_reg   <= '0;
         beat_idx_reg   <= '0;
         done_flag_reg  <= 1'b0;
      end else if (start_accept) begin
         mode_reg       <= (ctrl_mode == 2'd3) ? MODE_STRIDE : mode_e'(ctrl_mode);
         base_reg       <= ctrl_addr_offset;
         inc_reg        <= addr_increment;
         max_reg        <= mem_max_addr;
         offset_reg     <= '0;
         xfer_bytes_reg <= ctrl_xfer_bytes;
         num_xfers_reg  <= ctrl_num_xfers;
         beats_reg      <= XW'(beats_round >> BEAT_SHIFT);
         beat_cnt_reg   <= '0;
         count_reg      <= '0;
         constant_reg   <= ctrl_constant;
         beat_idx_reg   <= '0;
         done_flag_reg  <= 1'b0;
      end else begin
         // A done that lands while streaming is held until WAIT consumes it
         if ((state_reg == ST_WAIT) && done_flag_reg) begin
            done_flag_reg <= 1'b0;
         end else if (write_done && (state_reg != ST_IDLE)) begin
            done_flag_reg <= 1'b1;
         end
         if (state_reg == ST_ISSUE) begin
            beat_cnt_reg <= '0;
         end else if (beat_fire) begin
            beat_cnt_reg <= beat_cnt_reg + XW'(1);
         end
         if (beat_fire) begin
            beat_idx_reg <= beat_idx_reg + 32'd1;
         end
         if (state_reg == ST_NEXT) begin
            count_reg  <= count_reg + XW'(1);
            offset_reg <= offset_next;
         end
      end
   end

   assign write_addr    = base_reg + C_M_AXI_ADDR_WIDTH'(offset_reg);
   assign out_data_size = xfer_bytes_reg;
   assign xfer_count    = count_reg;
   assign beat_base     = constant_reg + beat_idx_reg * 32'(LANES);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign out_data[gi*32 +: 32] = out_data_valid ? (beat_base + 32'(gi)) : 32'd0;
      end
   endgenerate

endmodule
